// File: rtl/lockin_pkg.sv
// Shared definitions for the lock-in demodulator datapath: FSM encoding,
// harmonic-table constants and a width helper.
// Latency: n/a (package). Backpressure: n/a.
package lockin_pkg;

  // Sequencer states of the time-multiplexed demodulation engine.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_MUL   = 3'd3,
    S_UPD   = 3'd4,
    S_DONE  = 3'd5
  } demod_state_t;

  // Width of one harmonic-table entry and the code that disables a channel.
  localparam int HARM_W = 4;
  localparam logic [HARM_W-1:0] HARM_OFF = 4'd0;

  // Ceiling log2, never below 1 so that single-entry selects still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/harmonic_demod_iir_step.sv
// One first-order IIR step: x_next = x + ((target - x) >>> tc).
// Latency: combinational. Backpressure: none.
// Ports: x (current state), target (new product), tc (shift), x_next (result).
module iir_step #(
  parameter int OW  = 32,
  parameter int TCW = 4
) (
  input  logic signed [OW-1:0]  x,
  input  logic signed [OW-1:0]  target,
  input  logic [TCW-1:0]        tc,
  output logic signed [OW-1:0]  x_next
);

  logic signed [OW:0] diff;
  logic signed [OW:0] step;
  logic signed [OW:0] sum;
  logic               unused_sum_msb;

  // The difference needs one extra bit; the sum is a convex combination of
  // x and target, so it always fits back into OW bits and the MSB is dropped.
  always_comb begin
    diff   = {target[OW-1], target} - {x[OW-1], x};
    step   = diff >>> tc;
    sum    = {x[OW-1], x} + step;
    x_next = sum[OW-1:0];
  end

  assign unused_sum_msb = sum[OW];

endmodule

// File: rtl/harmonic_demod.sv
// Multi-channel, multi-harmonic dual-phase demodulator: one multiplier pair
// and one IIR pair shared across NCH channels, each with its own harmonic.
// Latency: done at accept+1+sum(channel cycles); enabled channel LUT_LAT+3
// cycles, disabled channel 1 cycle.
// Backpressure: none; a sample_valid arriving while busy is dropped and
// latches the sticky overrun flag.
// Ports: CLK36/rst; sample/sample_valid/phase/tc from the ADC host;
// harm_wr/harm_ch/harm_val harmonic-table write; lut_phase out and
// lut_sin/lut_cos back from the shared lookup; busy/done/overrun status;
// rd_ch selects the registered I/Q read-back on rd_x/rd_y.
module harmonic_demod
  import lockin_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 16,
  parameter int PW      = 18,
  parameter int OW      = 32,
  parameter int LUT_LAT = 2,
  parameter int TCW     = 4
) (
  input  logic                   CLK36,
  input  logic                   rst,
  input  logic signed [DW-1:0]   sample,
  input  logic                   sample_valid,
  input  logic [PW-1:0]          phase,
  input  logic [TCW-1:0]         tc,
  input  logic                   harm_wr,
  input  logic [clog2(NCH)-1:0]  harm_ch,
  input  logic [HARM_W-1:0]      harm_val,
  output logic [PW-1:0]          lut_phase,
  input  logic signed [DW-1:0]   lut_sin,
  input  logic signed [DW-1:0]   lut_cos,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  input  logic [clog2(NCH)-1:0]  rd_ch,
  output logic signed [OW-1:0]   rd_x,
  output logic signed [OW-1:0]   rd_y
);

  localparam int CHW = clog2(NCH);
  localparam int WCW = clog2(LUT_LAT);

  if (OW < 2 * DW) begin : g_bad_ow
    $error("harmonic_demod: OW must be at least 2*DW");
  end

  demod_state_t state, state_n;

  // Sample context latched at accept.
  logic signed [DW-1:0]  sample_q;
  logic [PW-1:0]         phase_q;
  logic [TCW-1:0]        tc_q;

  // Channel sequencing.
  logic [CHW-1:0]        ch;
  logic [WCW-1:0]        wcnt;
  logic                  last_ch;
  logic [HARM_W-1:0]     harm_cur;
  logic [PW-1:0]         phase_mul;

  // Per-channel harmonic table and filter state.
  logic [HARM_W-1:0]     harm [NCH];
  logic signed [OW-1:0]  xs   [NCH];
  logic signed [OW-1:0]  ys   [NCH];

  // Multiplier outputs and IIR results.
  logic signed [2*DW-1:0] prod_s;
  logic signed [2*DW-1:0] prod_c;
  logic signed [OW-1:0]   px;
  logic signed [OW-1:0]   py;
  logic signed [OW-1:0]   x_next;
  logic signed [OW-1:0]   y_next;

  logic                  harm_ch_ok;
  logic                  rd_ok;

  assign harm_cur   = harm[ch];
  assign last_ch    = (ch == CHW'(NCH - 1));
  // Evaluated at PW bits, so the product wraps modulo 2^PW as a phase should.
  assign phase_mul  = phase_q * PW'(harm_cur);
  assign prod_s     = lut_sin * sample_q;
  assign prod_c     = lut_cos * sample_q;
  // One spare MSB keeps these compares meaningful when NCH is a power of two.
  assign harm_ch_ok = ({1'b0, harm_ch} < (CHW + 1)'(NCH));
  assign rd_ok      = ({1'b0, rd_ch} < (CHW + 1)'(NCH));

  iir_step #(.OW(OW), .TCW(TCW)) u_iir_x (
    .x      (xs[ch]),
    .target (px),
    .tc     (tc_q),
    .x_next (x_next)
  );

  iir_step #(.OW(OW), .TCW(TCW)) u_iir_y (
    .x      (ys[ch]),
    .target (py),
    .tc     (tc_q),
    .x_next (y_next)
  );

  // State register.
  always_ff @(posedge CLK36) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_n = state;
    busy    = (state != S_IDLE);
    done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sample_valid) begin
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (harm_cur == HARM_OFF) begin
          state_n = last_ch ? S_DONE : S_ISSUE;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt == WCW'(LUT_LAT - 1)) begin
          state_n = S_MUL;
        end
      end
      S_MUL: begin
        state_n = S_UPD;
      end
      S_UPD: begin
        state_n = last_ch ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath, harmonic table, filter arrays and read port.
  always_ff @(posedge CLK36) begin
    if (rst) begin
      sample_q  <= '0;
      phase_q   <= '0;
      tc_q      <= '0;
      ch        <= '0;
      wcnt      <= '0;
      lut_phase <= '0;
      px        <= '0;
      py        <= '0;
      overrun   <= 1'b0;
      rd_x      <= '0;
      rd_y      <= '0;
      for (int i = 0; i < NCH; i++) begin
        harm[i] <= (i + 1 > 15) ? HARM_W'(15) : HARM_W'(i + 1);
        xs[i]   <= '0;
        ys[i]   <= '0;
      end
    end else begin
      if (state == S_IDLE) begin
        if (sample_valid) begin
          sample_q <= sample;
          phase_q  <= phase;
          tc_q     <= tc;
          ch       <= '0;
        end
        // Table writes only land between samples so a running sample sees a
        // consistent harmonic set; a rewritten channel restarts from zero.
        if (harm_wr && harm_ch_ok) begin
          harm[harm_ch] <= harm_val;
          xs[harm_ch]   <= '0;
          ys[harm_ch]   <= '0;
        end
      end else if (sample_valid) begin
        overrun <= 1'b1;
      end

      case (state)
        S_ISSUE: begin
          wcnt <= '0;
          if (harm_cur == HARM_OFF) begin
            if (!last_ch) begin
              ch <= ch + CHW'(1);
            end
          end else begin
            lut_phase <= phase_mul;
          end
        end
        S_WAIT: begin
          wcnt <= wcnt + WCW'(1);
        end
        S_MUL: begin
          // Left-align the full product in the filter word.
          px <= OW'(prod_s) <<< (OW - 2 * DW);
          py <= OW'(prod_c) <<< (OW - 2 * DW);
        end
        S_UPD: begin
          xs[ch] <= x_next;
          ys[ch] <= y_next;
          if (!last_ch) begin
            ch <= ch + CHW'(1);
          end
        end
        default: begin
        end
      endcase

      // Bypass the array so a read of the channel being updated shows the
      // new value one cycle after UPD rather than two.
      if (!rd_ok) begin
        rd_x <= '0;
        rd_y <= '0;
      end else if ((state == S_UPD) && (ch == rd_ch)) begin
        rd_x <= x_next;
        rd_y <= y_next;
      end else begin
        rd_x <= xs[rd_ch];
        rd_y <= ys[rd_ch];
      end
    end
  end

endmodule

// File: tb/tb_harmonic_demod.sv
// Directed self-checking bench for harmonic_demod with a two-cycle lookup model.
// Latency: n/a. Backpressure: n/a.
// Ports: none (top-level bench).
module tb_harmonic_demod;

  logic                CLK36 = 1'b0;
  logic                rst;
  logic signed [15:0]  sample;
  logic                sample_valid;
  logic [17:0]         phase;
  logic [3:0]          tc;
  logic                harm_wr;
  logic [1:0]          harm_ch;
  logic [3:0]          harm_val;
  logic [17:0]         lut_phase;
  logic signed [15:0]  lut_sin;
  logic signed [15:0]  lut_cos;
  logic                busy;
  logic                done;
  logic                overrun;
  logic [1:0]          rd_ch;
  logic signed [31:0]  rd_x;
  logic signed [31:0]  rd_y;

  always #5 CLK36 = ~CLK36;

  harmonic_demod #(
    .NCH(4), .DW(16), .PW(18), .OW(32), .LUT_LAT(2), .TCW(4)
  ) dut (
    .CLK36        (CLK36),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .phase        (phase),
    .tc           (tc),
    .harm_wr      (harm_wr),
    .harm_ch      (harm_ch),
    .harm_val     (harm_val),
    .lut_phase    (lut_phase),
    .lut_sin      (lut_sin),
    .lut_cos      (lut_cos),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .rd_ch        (rd_ch),
    .rd_x         (rd_x),
    .rd_y         (rd_y)
  );

  // Lookup model, two register stages. Mode 0 returns constants; mode 1
  // returns sin = low 16 phase bits, cos = -sin, so values expose which
  // phase was sampled.
  logic               lut_mode;
  logic signed [15:0] sin_c, cos_c, s1, c1;
  always @(posedge CLK36) begin
    s1      <= lut_mode ? $signed(lut_phase[15:0]) : sin_c;
    c1      <= lut_mode ? -$signed(lut_phase[15:0]) : cos_c;
    lut_sin <= s1;
    lut_cos <= c1;
  end

  int          cyc = 0;
  int          t0 = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [17:0] lp_last = '0;
  logic [17:0] lp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge CLK36) cyc++;

  always @(negedge CLK36) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (lut_phase != lp_last) begin
      lp_q.push_back(lut_phase);
      lp_last = lut_phase;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK36);
    rst = 1'b1;
    @(negedge CLK36);
    rst = 1'b0;
  endtask

  task automatic wr_harm(input int c, input int v);
    @(negedge CLK36);
    harm_wr  = 1'b1;
    harm_ch  = 2'(c);
    harm_val = 4'(v);
    @(negedge CLK36);
    harm_wr  = 1'b0;
  endtask

  // Drives a one-cycle strobe; returns at the negedge of accept+1.
  task automatic send(input int s, input int ph, input int t);
    @(negedge CLK36);
    sample       = 16'(s);
    phase        = 18'(ph);
    tc           = 4'(t);
    sample_valid = 1'b1;
    t0           = cyc;
    lp_q.delete();
    @(negedge CLK36);
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int k;
    k = 0;
    while (done_cnt == n0 && k < 200) begin
      @(posedge CLK36);
      k++;
    end
    if (done_cnt == n0) chk("done_timeout", 0, 1);
    @(negedge CLK36);
  endtask

  task automatic rd(input int c, output longint x, output longint y);
    @(negedge CLK36);
    rd_ch = 2'(c);
    @(negedge CLK36);
    @(negedge CLK36);
    x = rd_x;
    y = rd_y;
  endtask

  task automatic chk_seq(input string tag, input int n, input int e0, input int e1,
                         input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_len"}, lp_q.size(), n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_%0d", tag, i), (i < lp_q.size()) ? longint'(lp_q[i]) : -1, e[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint x, y;
    int     n0;
    rst = 1'b1; sample = '0; sample_valid = 1'b0; phase = '0; tc = '0;
    harm_wr = 1'b0; harm_ch = '0; harm_val = '0; rd_ch = '0;
    lut_mode = 1'b0; sin_c = 16'sd16384; cos_c = 16'sd0;
    repeat (3) @(negedge CLK36);
    rst = 1'b0;

    // Reset state.
    @(negedge CLK36);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_lut_phase", lut_phase, 0);
    for (int c = 0; c < 4; c++) begin
      rd(c, x, y);
      chk($sformatf("rst_x%0d", c), x, 0);
      chk($sformatf("rst_y%0d", c), y, 0);
    end

    // tc=0, all harmonics 1: state becomes the product, done at t0+21.
    for (int c = 0; c < 4; c++) wr_harm(c, 1);
    n0 = done_cnt;
    send(16384, 0, 0);
    chk("a_busy_t1", busy, 1);
    wait_done(n0);
    chk("a_done_lat", done_cyc - t0, 21);
    chk("a_busy_t22", busy, 0);
    for (int c = 0; c < 4; c++) begin
      rd(c, x, y);
      chk($sformatf("a_x%0d", c), x, 268435456);
      chk($sformatf("a_y%0d", c), y, 0);
    end

    // tc=4 step response over two samples.
    do_reset();
    n0 = done_cnt;
    send(16384, 0, 4);
    wait_done(n0);
    rd(0, x, y); chk("b1_x0", x, 16777216);
    rd(3, x, y); chk("b1_x3", x, 16777216);
    n0 = done_cnt;
    send(16384, 0, 4);
    wait_done(n0);
    rd(0, x, y); chk("b2_x0", x, 32505856);
    rd(3, x, y); chk("b2_x3", x, 32505856);

    // Harmonics {1,3,5,0}: phase products wrap, channel 3 skipped.
    do_reset();
    wr_harm(1, 3);
    wr_harm(2, 5);
    wr_harm(3, 0);
    n0 = done_cnt;
    send(16384, 'h10000, 0);
    wait_done(n0);
    chk("c_done_lat", done_cyc - t0, 17);
    chk_seq("c_lp", 3, 'h10000, 'h30000, 'h10000, 0);
    for (int c = 0; c < 3; c++) begin
      rd(c, x, y);
      chk($sformatf("c_x%0d", c), x, 268435456);
    end
    rd(3, x, y); chk("c_x3_held", x, 0);

    // Strobe while busy: dropped, sticky overrun, results unchanged.
    do_reset();
    n0 = done_cnt;
    send(16384, 0, 0);
    while (cyc < t0 + 5) @(negedge CLK36);
    sample = 16'sd100; sample_valid = 1'b1;
    @(negedge CLK36);
    sample_valid = 1'b0;
    wait_done(n0);
    chk("d_done_lat", done_cyc - t0, 21);
    chk("d_overrun", overrun, 1);
    repeat (30) @(negedge CLK36);
    chk("d_done_once", done_cnt - n0, 1);
    chk("d_overrun_sticky", overrun, 1);
    for (int c = 0; c < 4; c++) begin
      rd(c, x, y);
      chk($sformatf("d_x%0d", c), x, 268435456);
    end
    do_reset();
    @(negedge CLK36);
    chk("d_overrun_clr", overrun, 0);

    // harm_wr while busy is ignored; in IDLE it applies and clears the channel.
    lut_mode = 1'b1;
    do_reset();
    n0 = done_cnt;
    send(64, 'h100, 0);
    while (cyc < t0 + 3) @(negedge CLK36);
    harm_wr = 1'b1; harm_ch = 2'd2; harm_val = 4'd7;
    @(negedge CLK36);
    harm_wr = 1'b0;
    wait_done(n0);
    chk_seq("e1_lp", 4, 'h100, 'h200, 'h300, 'h400);
    rd(2, x, y);
    chk("e1_x2", x, 49152);
    chk("e1_y2", y, -49152);
    wr_harm(2, 7);
    rd(2, x, y);
    chk("e_clr_x2", x, 0);
    chk("e_clr_y2", y, 0);
    rd(1, x, y);
    chk("e_keep_x1", x, 32768);
    n0 = done_cnt;
    send(64, 'h100, 0);
    wait_done(n0);
    chk_seq("e2_lp", 4, 'h100, 'h200, 'h700, 'h400);
    rd(2, x, y);
    chk("e2_x2", x, 114688);
    chk("e2_y2", y, -114688);

    // Reset mid-sample: immediate abort, no done, defaults restored.
    n0 = done_cnt;
    send(64, 'h100, 0);
    while (cyc < t0 + 10) @(negedge CLK36);
    rst = 1'b1;
    @(negedge CLK36);
    rst = 1'b0;
    chk("f_busy", busy, 0);
    repeat (30) @(negedge CLK36);
    chk("f_no_done", done_cnt - n0, 0);
    for (int c = 0; c < 4; c++) begin
      rd(c, x, y);
      chk($sformatf("f_x%0d", c), x, 0);
    end
    n0 = done_cnt;
    send(64, 'h100, 0);
    wait_done(n0);
    chk_seq("f_lp", 4, 'h100, 'h200, 'h300, 'h400);
    rd(2, x, y);
    chk("f_x2", x, 49152);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
